stopwatch_core: RTL and testbench



---
 rtl/stopwatch_core.sv | 88 ++++++++
 tb/tb_stopwatch_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core: tenths-of-a-second stopwatch with start/stop, lap freeze and clear,
// button-controlled only in timer mode; the count runs in every mode.
module stopwatch_core #(
    parameter int         DIV      = 10,
    parameter logic [1:0] M1_TIMER = 2'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       increase,
    input  logic       set,
    input  logic [1:0] mode1,
    output logic [5:0] min_sw,
    output logic [5:0] sec_sw,
    output logic [3:0] secc_sw,
    output logic       running,
    output logic       wrapped
);
    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;
    localparam logic [9:0] PMAX = 10'(DIV - 1);
    state_t     state_q, state_d;
    logic       inc_q, set_q, run_q, run_d, wrap_q, wrap_d;
    logic [9:0] pre_q, pre_d;
    logic [5:0] min_q, min_d, sec_q, sec_d, dmin_q, dmin_d, dsec_q, dsec_d;
    logic [3:0] ten_q, ten_d, dten_q, dten_d;
    logic       timer, inc_e, set_e, act, tick, clear, ten_c, sec_c, min_c;
    always_comb begin
        timer   = mode1 == M1_TIMER;
        inc_e   = increase & ~inc_q & timer;
        set_e   = set & ~set_q & timer & ~inc_e;
        act     = state_q == RUN || state_q == LAP;
        tick    = act && pre_q == PMAX;
        clear   = state_q == STOP && set_e;
        ten_c   = tick && ten_q == 4'd9;
        sec_c   = ten_c && sec_q == 6'd59;
        min_c   = sec_c && min_q == 6'd59;
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = inc_e ? RUN : IDLE;
            RUN:  state_d = inc_e ? STOP : set_e ? LAP : RUN;
            LAP:  state_d = inc_e ? STOP : set_e ? RUN : LAP;
            STOP: state_d = inc_e ? RUN : set_e ? IDLE : STOP;
        endcase
        pre_d  = (clear || state_q == IDLE || tick) ? 10'd0 : act ? pre_q + 10'd1 : pre_q;
        ten_d  = clear ? 4'd0 : tick ? (ten_c ? 4'd0 : ten_q + 4'd1) : ten_q;
        sec_d  = clear ? 6'd0 : ten_c ? (sec_c ? 6'd0 : sec_q + 6'd1) : sec_q;
        min_d  = clear ? 6'd0 : sec_c ? (min_c ? 6'd0 : min_q + 6'd1) : min_q;
        wrap_d = clear ? 1'b0 : wrap_q | min_c;
        run_d  = state_d == RUN || state_d == LAP;
        // In LAP the display holds; entering LAP it still samples the pre-tick count.
        dmin_d = state_q == LAP ? dmin_q : min_q;
        dsec_d = state_q == LAP ? dsec_q : sec_q;
        dten_d = state_q == LAP ? dten_q : ten_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            inc_q   <= increase;
            set_q   <= set;
            pre_q   <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            ten_q   <= '0;
            dmin_q  <= '0;
            dsec_q  <= '0;
            dten_q  <= '0;
            wrap_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= increase;
            set_q   <= set;
            pre_q   <= pre_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            ten_q   <= ten_d;
            dmin_q  <= dmin_d;
            dsec_q  <= dsec_d;
            dten_q  <= dten_d;
            wrap_q  <= wrap_d;
            run_q   <= run_d;
        end
    end
    assign min_sw  = dmin_q;
    assign sec_sw  = dsec_q;
    assign secc_sw = dten_q;
    assign running = run_q;
    assign wrapped = wrap_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scoreboard bench; DIV=1 and DIV=10 instances share stimulus.
module tb_stopwatch_core;
    logic       clk = 1'b0, reset = 1'b1, increase = 1'b0, set = 1'b0;
    logic [1:0] mode1 = 2'd1;
    logic [5:0] m1, s1, m10, s10;
    logic [3:0] t1, t10;
    logic       r1, w1, r10, w10;
    int         total = 0, bad = 0;
    typedef struct {
        string       name;
        bit          sel;
        logic [17:0] exp;
    } exp_t;
    exp_t        q[$];
    exp_t        e;
    logic [17:0] a;
    stopwatch_core #(.DIV(1), .M1_TIMER(2'd1)) u1 (
        .clk(clk), .reset(reset), .increase(increase), .set(set), .mode1(mode1),
        .min_sw(m1), .sec_sw(s1), .secc_sw(t1), .running(r1), .wrapped(w1));
    stopwatch_core #(.DIV(10), .M1_TIMER(2'd1)) u10 (
        .clk(clk), .reset(reset), .increase(increase), .set(set), .mode1(mode1),
        .min_sw(m10), .sec_sw(s10), .secc_sw(t10), .running(r10), .wrapped(w10));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            a = e.sel ? {m10, s10, t10, r10, w10} : {m1, s1, t1, r1, w1};
            total++;
            if (a !== e.exp) begin
                bad++;
                $display("FAIL %s got %0d:%0d.%0d run=%b wrap=%b exp %0d:%0d.%0d run=%b wrap=%b",
                         e.name, a[17:12], a[11:6], a[5:2], a[1], a[0],
                         e.exp[17:12], e.exp[11:6], e.exp[5:2], e.exp[1], e.exp[0]);
            end
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic expect_v(input string n, input bit sel, input int m, input int s,
                            input int t, input bit r, input bit w);
        q.push_back('{n, sel, {6'(m), 6'(s), 4'(t), r, w}});
    endtask
    task automatic pulse_inc();
        increase = 1'b1;
        step(1);
        increase = 1'b0;
    endtask
    task automatic pulse_set();
        set = 1'b1;
        step(1);
        set = 1'b0;
    endtask
    initial begin
        step(2);
        reset = 1'b0;
        expect_v("reset_u1", 0, 0, 0, 0, 0, 0);
        expect_v("reset_u10", 1, 0, 0, 0, 0, 0);
        step(1);
        // start, 25 ticks, stop
        pulse_inc();
        step(24);
        pulse_inc();
        step(1);
        expect_v("stop_2.5", 0, 0, 2, 5, 0, 0);
        step(100);
        expect_v("stop_hold", 0, 0, 2, 5, 0, 0);
        pulse_set();
        step(1);
        expect_v("clear1", 0, 0, 0, 0, 0, 0);
        // lap freeze at 1.0, resume at 6.0
        pulse_inc();
        step(10);
        pulse_set();
        expect_v("lap_enter", 0, 0, 1, 0, 1, 0);
        step(48);
        expect_v("lap_hold", 0, 0, 1, 0, 1, 0);
        pulse_set();
        step(1);
        expect_v("lap_resume", 0, 0, 6, 0, 1, 0);
        pulse_inc();
        pulse_set();
        step(1);
        expect_v("clear2", 0, 0, 0, 0, 0, 0);
        // full roll 59:59.9 -> 00:00.0
        pulse_inc();
        step(35999);
        expect_v("pre_wrap", 0, 59, 59, 8, 1, 0);
        step(2);
        expect_v("wrap", 0, 0, 0, 0, 1, 1);
        pulse_inc();
        step(1);
        expect_v("wrap_sticky", 0, 0, 0, 2, 0, 1);
        pulse_set();
        step(1);
        expect_v("wrap_clear", 0, 0, 0, 0, 0, 0);
        // buttons ignored outside timer mode, counting continues
        mode1 = 2'd0;
        pulse_inc();
        pulse_set();
        step(3);
        expect_v("mode_ignore", 0, 0, 0, 0, 0, 0);
        mode1 = 2'd1;
        pulse_inc();
        mode1 = 2'd0;
        step(9);
        expect_v("mode_count", 0, 0, 0, 8, 1, 0);
        pulse_inc();
        step(1);
        expect_v("mode_no_stop", 0, 0, 1, 0, 1, 0);
        mode1 = 2'd1;
        pulse_inc();
        pulse_set();
        step(1);
        expect_v("clear3", 0, 0, 0, 0, 0, 0);
        // simultaneous edges: increase wins
        pulse_inc();
        step(5);
        increase = 1'b1;
        set = 1'b1;
        step(1);
        increase = 1'b0;
        set = 1'b0;
        step(1);
        expect_v("simul_stop", 0, 0, 0, 6, 0, 0);
        increase = 1'b1;
        step(20);
        expect_v("held_once", 0, 0, 2, 4, 1, 0);
        increase = 1'b0;
        step(1);
        pulse_inc();
        pulse_set();
        step(1);
        expect_v("clear4", 0, 0, 0, 0, 0, 0);
        // DIV=10 run, then reset with increase held
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        pulse_inc();
        step(95);
        expect_v("div10_run", 1, 0, 0, 9, 1, 0);
        increase = 1'b1;
        reset = 1'b1;
        step(1);
        expect_v("abort_u10", 1, 0, 0, 0, 0, 0);
        expect_v("abort_u1", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(5);
        expect_v("held_reset_u10", 1, 0, 0, 0, 0, 0);
        expect_v("held_reset_u1", 0, 0, 0, 0, 0, 0);
        increase = 1'b0;
        step(2);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d exp 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
